// File: rtl/pwm_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl_if
// Description : Control/status bundle between the sequencer and its controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_ramp_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             en;
    logic             once;
    logic             period_end;
    logic [CNT_W-1:0] duty;
    logic             duty_load;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    modport master (
        output en, once, period_end,
        input  duty, duty_load, busy, done, state
    );

    modport slave (
        input  en, once, period_end,
        output duty, duty_load, busy, done, state
    );
endinterface
`default_nettype wire

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ramp_ctrl
// Description : Breathing duty-cycle sequencer; all duty updates land on PWM
//               period boundaries except an en-drop abort.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl #(
    parameter int CNT_W            = 4,
    parameter int DUTY_MAX         = 15,
    parameter int STEP             = 1,
    parameter int PERIODS_PER_STEP = 4,
    parameter int HOLD_PERIODS     = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pwm_ramp_ctrl_if.slave  bus
);

    localparam int C_SW = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
    localparam int C_HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

    localparam logic [C_SW-1:0]  C_STEP_LAST = C_SW'(PERIODS_PER_STEP - 1);
    localparam logic [C_HW-1:0]  C_HOLD_LAST = C_HW'(HOLD_PERIODS - 1);
    localparam logic [CNT_W:0]   C_STEP_X    = (CNT_W+1)'(STEP);
    localparam logic [CNT_W:0]   C_MAX_X     = (CNT_W+1)'(DUTY_MAX);
    localparam logic [CNT_W-1:0] C_MAX_D     = CNT_W'(DUTY_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAMP_UP = 3'd1,
        S_HOLD_HI = 3'd2,
        S_RAMP_DN = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_duty;
    logic [C_SW-1:0]  r_step_cnt;
    logic [C_HW-1:0]  r_hold_cnt;
    logic             r_duty_load;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_duty_nxt;
    logic [C_SW-1:0]  w_step_nxt;
    logic [C_HW-1:0]  w_hold_nxt;
    logic             w_done_nxt;

    // Ramp arithmetic is one bit wider than duty so the ceiling test cannot wrap.
    logic [CNT_W:0]   w_sum_up;
    logic             w_up_sat;
    logic             w_dn_sat;
    logic [CNT_W-1:0] w_diff_dn;

    assign w_sum_up  = {1'b0, r_duty} + C_STEP_X;
    assign w_up_sat  = (w_sum_up >= C_MAX_X);
    assign w_dn_sat  = ({1'b0, r_duty} <= C_STEP_X);
    assign w_diff_dn = r_duty - C_STEP_X[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_duty      <= '0;
            r_step_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_duty_load <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_duty      <= w_duty_nxt;
            r_step_cnt  <= w_step_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_duty_load <= (w_duty_nxt != r_duty);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_step_nxt  = r_step_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_done_nxt  = 1'b0;

        if (!bus.en) begin
            // Abort wins over period_end and never raises done.
            w_state_nxt = S_IDLE;
            w_duty_nxt  = '0;
            w_step_nxt  = '0;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_duty_nxt = '0;
                    w_step_nxt = '0;
                    w_hold_nxt = '0;
                    if (bus.period_end) begin
                        w_state_nxt = S_RAMP_UP;
                    end
                end
                S_RAMP_UP: begin
                    if (bus.period_end) begin
                        if (r_step_cnt == C_STEP_LAST) begin
                            w_step_nxt = '0;
                            if (w_up_sat) begin
                                w_duty_nxt  = C_MAX_D;
                                w_state_nxt = S_HOLD_HI;
                            end else begin
                                w_duty_nxt = w_sum_up[CNT_W-1:0];
                            end
                        end else begin
                            w_step_nxt = r_step_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD_HI: begin
                    if (bus.period_end) begin
                        if (r_hold_cnt == C_HOLD_LAST) begin
                            w_hold_nxt  = '0;
                            w_state_nxt = S_RAMP_DN;
                        end else begin
                            w_hold_nxt = r_hold_cnt + 1'b1;
                        end
                    end
                end
                S_RAMP_DN: begin
                    if (bus.period_end) begin
                        if (r_step_cnt == C_STEP_LAST) begin
                            w_step_nxt = '0;
                            if (w_dn_sat) begin
                                w_duty_nxt  = '0;
                                w_state_nxt = S_HOLD_LO;
                            end else begin
                                w_duty_nxt = w_diff_dn;
                            end
                        end else begin
                            w_step_nxt = r_step_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD_LO: begin
                    if (bus.period_end) begin
                        if (r_hold_cnt == C_HOLD_LAST) begin
                            w_hold_nxt = '0;
                            w_step_nxt = '0;
                            if (bus.once) begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_RAMP_UP;
                            end
                        end else begin
                            w_hold_nxt = r_hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_duty_nxt  = '0;
                    w_step_nxt  = '0;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    assign bus.duty      = r_duty;
    assign bus.duty_load = r_duty_load;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_ramp_ctrl
// Description : Self-checking bench for pwm_ramp_ctrl against a profile model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_ctrl;

    logic clk;
    logic rst;
    logic en_d, en_s, once, pe, sel;

    int total = 0;
    int bad   = 0;
    int n_load;
    int m_duty;
    bit prof_once;

    typedef struct {
        int st;
        int dv;
    } ent_t;
    ent_t prof[$];

    pwm_ramp_ctrl_if #(.CNT_W(4)) ifd ();
    pwm_ramp_ctrl_if #(.CNT_W(4)) ifs ();

    assign ifd.en = en_d;
    assign ifd.once = once;
    assign ifd.period_end = pe;
    assign ifs.en = en_s;
    assign ifs.once = once;
    assign ifs.period_end = pe;

    pwm_ramp_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifd)
    );

    pwm_ramp_ctrl #(
        .CNT_W(4), .DUTY_MAX(15), .STEP(4), .PERIODS_PER_STEP(1), .HOLD_PERIODS(2)
    ) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (ifs)
    );

    logic [2:0] o_state;
    logic [3:0] o_duty;
    logic       o_load, o_busy, o_done;
    assign o_state = sel ? ifs.state     : ifd.state;
    assign o_duty  = sel ? ifs.duty      : ifd.duty;
    assign o_load  = sel ? ifs.duty_load : ifd.duty_load;
    assign o_busy  = sel ? ifs.busy      : ifd.busy;
    assign o_done  = sel ? ifs.done      : ifd.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic p);
        pe = p;
        @(posedge clk);
        #1;
    endtask

    // Expected (state, duty) after each successive period_end of one breath.
    task automatic build_profile(input int step, input int mx, input int pps,
                                 input int hp, input bit once_v);
        int v, nv;
        prof.delete();
        prof_once = once_v;
        prof.push_back('{1, 0});
        v = 0;
        while (v < mx) begin
            nv = (v + step >= mx) ? mx : v + step;
            repeat (pps - 1) prof.push_back('{1, v});
            prof.push_back('{(nv == mx) ? 2 : 1, nv});
            v = nv;
        end
        repeat (hp - 1) prof.push_back('{2, mx});
        prof.push_back('{3, mx});
        while (v > 0) begin
            nv = (v <= step) ? 0 : v - step;
            repeat (pps - 1) prof.push_back('{3, v});
            prof.push_back('{(nv == 0) ? 4 : 3, nv});
            v = nv;
        end
        repeat (hp - 1) prof.push_back('{4, 0});
        prof.push_back('{once_v ? 0 : 1, 0});
    endtask

    task automatic run_profile(input int first, input int last, input int fixed_gap);
        int gap;
        for (int i = first; i <= last; i++) begin
            gap = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(40, 3));
            for (int g = 1; g < gap; g++) begin
                tick(1'b0);
                chk("gap_duty", o_duty, m_duty);
                chk("gap_load", o_load, 0);
            end
            tick(1'b1);
            chk("pe_state", o_state, prof[i].st);
            chk("pe_duty", o_duty, prof[i].dv);
            chk("pe_load", o_load, (prof[i].dv != m_duty));
            chk("pe_busy", o_busy, (prof[i].st != 0));
            chk("pe_done", o_done, (prof_once && i == prof.size() - 1));
            if (o_load === 1'b1) n_load++;
            m_duty = prof[i].dv;
        end
    endtask

    initial begin
        int idx;
        rst = 1'b0; en_d = 1'b0; en_s = 1'b0; once = 1'b1; pe = 1'b0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", o_state, 0);
        chk("rst_duty", o_duty, 0);
        chk("rst_load", o_load, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        rst = 1'b1;

        // period_end with en low in IDLE is ignored
        tick(1'b1);
        chk("idle_pe_state", o_state, 0);
        chk("idle_pe_busy", o_busy, 0);

        // single breath, random period spacing
        build_profile(1, 15, 4, 8, 1'b1);
        chk("prof_len", prof.size(), 137);
        en_d = 1'b1; m_duty = 0; n_load = 0;
        run_profile(0, prof.size() - 1, 0);
        chk("load_cnt", n_load, 30);
        tick(1'b0);
        chk("after_state", o_state, 0);
        chk("after_busy", o_busy, 0);
        chk("after_done", o_done, 0);

        // continuous: two breaths back to back
        once = 1'b0;
        build_profile(1, 15, 4, 8, 1'b0);
        run_profile(0, prof.size() - 1, 16);
        run_profile(1, prof.size() - 1, 16);

        // abort at duty 0 leaves duty_load low
        en_d = 1'b0;
        tick(1'b0);
        chk("ab0_state", o_state, 0);
        chk("ab0_duty", o_duty, 0);
        chk("ab0_load", o_load, 0);
        chk("ab0_busy", o_busy, 0);

        // abort at duty 9 between period_ends
        once = 1'b1;
        build_profile(1, 15, 4, 8, 1'b1);
        idx = 0;
        while (!(prof[idx].dv == 9 && prof[idx].st == 1)) idx++;
        en_d = 1'b1; m_duty = 0;
        run_profile(0, idx, 16);
        tick(1'b0);
        tick(1'b0);
        chk("ab9_pre_duty", o_duty, 9);
        en_d = 1'b0;
        tick(1'b0);
        chk("ab9_state", o_state, 0);
        chk("ab9_duty", o_duty, 0);
        chk("ab9_load", o_load, 1);
        chk("ab9_busy", o_busy, 0);
        chk("ab9_done", o_done, 0);
        tick(1'b1);
        chk("ab9_load_end", o_load, 0);
        chk("ab9_idle", o_state, 0);

        // saturating ramps on the STEP=4 instance
        sel = 1'b1;
        build_profile(4, 15, 1, 2, 1'b1);
        en_s = 1'b1; m_duty = 0;
        run_profile(0, prof.size() - 1, 0);
        en_s = 1'b0;
        tick(1'b0);
        chk("sat_idle", o_state, 0);
        sel = 1'b0;

        // async reset in the middle of HOLD_HI
        build_profile(1, 15, 4, 8, 1'b1);
        idx = 0;
        while (prof[idx].st != 2) idx++;
        idx = idx + 2;
        en_d = 1'b1; m_duty = 0;
        run_profile(0, idx, 16);
        tick(1'b0);
        chk("pre_rst_state", o_state, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", o_state, 0);
        chk("arst_duty", o_duty, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_load", o_load, 0);
        chk("arst_done", o_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_duty = 0;
        run_profile(0, 12, 16);

        en_d = 1'b0;
        tick(1'b0);
        chk("final_state", o_state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
